// File: rtl/param_sa_loader.sv
// param_sa_loader: NxN weight-stationary systolic-array loader. Fetches a weight tile or feature
// window through one sync-read port, shifts weight rows into the array, then streams skewed features.
module param_sa_loader #(
  parameter int DATA_W = 8,
  parameter int N      = 2,
  parameter int ADDR_W = 6,
  parameter int FMAP_W = 4,
  parameter int W_BASE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wl_start,
  input  logic                fl_start,
  input  logic [ADDR_W-1:0]   feature_baseaddr,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                w_shift,
  output logic [N*DATA_W-1:0] w_data,
  output logic [N-1:0]        f_valid,
  output logic [N*DATA_W-1:0] f_data,
  output logic                busy,
  output logic                w_loaded,
  output logic                is_WL_done_o,
  output logic                is_FL_done_o,
  output logic                err_o
);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(2 * N);
  localparam logic [RW-1:0]     LAST_IDX   = RW'(N - 1);
  localparam logic [CW-1:0]     LAST_SHIFT = CW'(N - 1);
  localparam logic [CW-1:0]     LAST_STEP  = CW'(2 * N - 2);
  localparam logic [ADDR_W-1:0] W_STRIDE   = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] F_STRIDE   = ADDR_W'(FMAP_W);
  localparam logic [ADDR_W-1:0] W_ORIGIN   = ADDR_W'(W_BASE);

  typedef enum logic [2:0] {IDLE, W_FETCH, W_SHIFT, F_FETCH, F_STREAM} state_t;

  state_t                state, next_state;
  logic [RW-1:0]         rd_row, rd_col, cap_row, cap_col, w_row;
  logic [CW-1:0]         step;
  logic                  rd_done, cap_valid, last_cap;
  logic                  accept_w, accept_f, wl_finish, fl_finish;
  logic [ADDR_W-1:0]     row_base;
  logic [DATA_W-1:0]     tile [N][N];

  assign accept_w  = (state == IDLE) && wl_start;
  assign accept_f  = (state == IDLE) && !wl_start && fl_start && w_loaded;
  assign last_cap  = cap_valid && (cap_row == LAST_IDX) && (cap_col == LAST_IDX);
  assign wl_finish = (state == W_SHIFT) && (step == LAST_SHIFT);
  assign fl_finish = (state == F_STREAM) && (step == LAST_STEP);
  assign w_row     = LAST_IDX - step[RW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept_w)      next_state = W_FETCH;
        else if (accept_f) next_state = F_FETCH;
      end
      W_FETCH:  if (last_cap)  next_state = W_SHIFT;
      W_SHIFT:  if (wl_finish) next_state = IDLE;
      F_FETCH:  if (last_cap)  next_state = F_STREAM;
      F_STREAM: if (fl_finish) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Read sequencing walks row_base down the rows so addresses are base + r*stride + c, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_row       <= '0;
      rd_col       <= '0;
      rd_done      <= 1'b0;
      row_base     <= '0;
      step         <= '0;
      cap_valid    <= 1'b0;
      cap_row      <= '0;
      cap_col      <= '0;
      w_loaded     <= 1'b0;
      is_WL_done_o <= 1'b0;
      is_FL_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      cap_valid    <= mem_rd_en;
      cap_row      <= rd_row;
      cap_col      <= rd_col;
      is_WL_done_o <= wl_finish;
      is_FL_done_o <= fl_finish;
      err_o        <= (state == IDLE) && fl_start && !wl_start && !w_loaded;
      if (accept_w)       w_loaded <= 1'b0;
      else if (wl_finish) w_loaded <= 1'b1;
      if (accept_w || accept_f) begin
        rd_row   <= '0;
        rd_col   <= '0;
        rd_done  <= 1'b0;
        step     <= '0;
        row_base <= accept_w ? W_ORIGIN : feature_baseaddr;
      end else begin
        if (mem_rd_en) begin
          if (rd_col == LAST_IDX) begin
            rd_col   <= '0;
            row_base <= row_base + ((state == W_FETCH) ? W_STRIDE : F_STRIDE);
            if (rd_row == LAST_IDX) rd_done <= 1'b1;
            else                    rd_row  <= rd_row + RW'(1);
          end else begin
            rd_col <= rd_col + RW'(1);
          end
        end
        if (state == W_SHIFT || state == F_STREAM) step <= step + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_valid) tile[cap_row][cap_col] <= mem_rdata;
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    w_shift   = (state == W_SHIFT);
    busy      = (state != IDLE);
    if ((state == W_FETCH || state == F_FETCH) && !rd_done) begin
      mem_rd_en = 1'b1;
      mem_addr  = row_base + ADDR_W'(rd_col);
    end
  end

  // Lane i runs i cycles behind lane 0, so it presents tile row (step - i) while that is in range.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [CW-1:0] depth;
    logic          lane_on;
    assign depth   = step - CW'(i);
    assign lane_on = (state == F_STREAM) && (step >= CW'(i)) && (depth < CW'(N));
    assign f_valid[i] = lane_on;
    assign f_data[i*DATA_W +: DATA_W] = lane_on ? tile[depth[RW-1:0]][i] : '0;
    assign w_data[i*DATA_W +: DATA_W] = w_shift ? tile[w_row][i] : '0;
  end
endmodule

// File: tb/tb_param_sa_loader.sv
// tb_param_sa_loader: directed bench; a cycle-timeline reference model derives every output from
// the time since a load was accepted, with literal checks pinning read addresses and stream data.
module tb_param_sa_loader;
  localparam int DATA_W   = 8;
  localparam int N        = 2;
  localparam int ADDR_W   = 6;
  localparam int FMAP_W   = 4;
  localparam int W_BASE   = 0;
  localparam int NN       = N * N;
  localparam int SHIFT_AT = NN + 2;
  localparam int W_DONE   = NN + N + 2;
  localparam int F_DONE   = NN + 2 * N + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                wl_start = 1'b0;
  logic                fl_start = 1'b0;
  logic [ADDR_W-1:0]   feature_baseaddr = '0;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_rdata;
  logic                w_shift;
  logic [N*DATA_W-1:0] w_data;
  logic [N-1:0]        f_valid;
  logic [N*DATA_W-1:0] f_data;
  logic                busy, w_loaded, is_WL_done_o, is_FL_done_o, err_o;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int op = 0;
  int t0 = 0;
  logic [ADDR_W-1:0] m_base = '0;
  bit m_loaded = 1'b0;
  bit m_err = 1'b0;

  int rd_log[$];
  logic [N*DATA_W-1:0] w_log[$];
  logic [N+N*DATA_W-1:0] f_log[$];
  int err_cnt = 0, wdone_cnt = 0, fdone_cnt = 0, busy_cnt = 0;

  param_sa_loader #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W), .FMAP_W(FMAP_W), .W_BASE(W_BASE)) dut (
    .clk(clk), .rst(rst), .wl_start(wl_start), .fl_start(fl_start),
    .feature_baseaddr(feature_baseaddr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .w_shift(w_shift), .w_data(w_data), .f_valid(f_valid),
    .f_data(f_data), .busy(busy), .w_loaded(w_loaded), .is_WL_done_o(is_WL_done_o),
    .is_FL_done_o(is_FL_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] elem_addr(input int kind, input logic [ADDR_W-1:0] base,
                                                  input int r, input int c);
    if (kind == 1) return ADDR_W'(W_BASE + r * N + c);
    return ADDR_W'(int'(base) + r * FMAP_W + c);
  endfunction

  // Model: track which load is in flight and when it was accepted; everything else follows from timing.
  always @(posedge clk) begin : model
    int prev;
    prev = cyc;
    cyc  = cyc + 1;
    if (op != 0 && prev - t0 >= ((op == 1) ? W_DONE : F_DONE)) op = 0;
    m_err = 1'b0;
    if (rst && op == 0) begin
      if (wl_start) begin
        op = 1; t0 = prev; m_loaded = 1'b0;
      end else if (fl_start) begin
        if (m_loaded) begin
          op = 2; t0 = prev; m_base = feature_baseaddr;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    if (op == 1 && cyc - t0 == W_DONE) m_loaded = 1'b1;
  end

  always @(negedge rst) begin
    op = 0; m_loaded = 1'b0; m_err = 1'b0;
  end

  always @(negedge clk) begin : compare
    int rel, k, s, d;
    logic exp_rd, exp_shift, exp_busy, exp_wdone, exp_fdone, in_stream;
    logic [ADDR_W-1:0] exp_addr;
    logic [N*DATA_W-1:0] exp_wdata, exp_fdata;
    logic [N-1:0] exp_fvalid;
    rel = cyc - t0;
    exp_rd = 0; exp_shift = 0; exp_busy = 0; exp_wdone = 0; exp_fdone = 0; in_stream = 0;
    exp_addr = '0; exp_wdata = '0; exp_fdata = '0; exp_fvalid = '0;
    if (op != 0) begin
      exp_busy = (rel >= 1) && (rel < ((op == 1) ? W_DONE : F_DONE));
      if (rel >= 1 && rel <= NN) begin
        exp_rd = 1; k = rel - 1;
        exp_addr = elem_addr(op, m_base, k / N, k % N);
      end
      s = rel - SHIFT_AT;
      if (op == 1) begin
        exp_wdone = (rel == W_DONE);
        if (s >= 0 && s < N) begin
          exp_shift = 1;
          for (int i = 0; i < N; i++)
            exp_wdata[i*DATA_W +: DATA_W] = mem[elem_addr(1, m_base, N - 1 - s, i)];
        end
      end else begin
        exp_fdone = (rel == F_DONE);
        if (s >= 0 && s <= 2 * N - 2) begin
          in_stream = 1;
          for (int i = 0; i < N; i++) begin
            d = s - i;
            if (d >= 0 && d < N) begin
              exp_fvalid[i] = 1'b1;
              exp_fdata[i*DATA_W +: DATA_W] = mem[elem_addr(2, m_base, d, i)];
            end
          end
        end
      end
    end
    checkOutput("mem_rd_en", mem_rd_en, exp_rd);
    if (exp_rd) checkOutput("mem_addr", mem_addr, exp_addr);
    checkOutput("busy", busy, exp_busy);
    checkOutput("w_shift", w_shift, exp_shift);
    if (exp_shift) checkOutput("w_data", w_data, exp_wdata);
    checkOutput("f_valid", f_valid, exp_fvalid);
    if (in_stream) checkOutput("f_data", f_data, exp_fdata);
    checkOutput("is_WL_done_o", is_WL_done_o, exp_wdone);
    checkOutput("is_FL_done_o", is_FL_done_o, exp_fdone);
    checkOutput("err_o", err_o, m_err);
    checkOutput("w_loaded", w_loaded, m_loaded);
    if (mem_rd_en) rd_log.push_back(int'(mem_addr));
    if (w_shift) w_log.push_back(w_data);
    if (|f_valid) f_log.push_back({f_valid, f_data});
    if (err_o) err_cnt++;
    if (is_WL_done_o) wdone_cnt++;
    if (is_FL_done_o) fdone_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic applyStimulus(input bit wl, input bit fl, input logic [ADDR_W-1:0] base);
    @(negedge clk);
    wl_start = wl; fl_start = fl; feature_baseaddr = base;
    @(negedge clk);
    wl_start = 1'b0; fl_start = 1'b0;
  endtask

  task automatic waitDone(input bit weight, input string name);
    int start_cnt = weight ? wdone_cnt : fdone_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = weight ? (wdone_cnt != start_cnt) : (fdone_cnt != start_cnt);
    end
    checkOutput(name, seen, 1'b1);
  endtask

  task automatic checkReads(input string name, input int mark, input int a0, input int a1,
                            input int a2, input int a3);
    int exp_a[4];
    exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2; exp_a[3] = a3;
    checkOutput({name, "_count"}, rd_log.size() - mark, NN);
    for (int i = 0; i < NN; i++)
      checkOutput($sformatf("%s_%0d", name, i),
                  (mark + i < rd_log.size()) ? rd_log[mark + i] : -1, exp_a[i]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mark, wmark, fmark, ecnt, fdcnt;
    bit seen;
    int bases[3];
    for (int a = 0; a < 2**ADDR_W; a++) mem[a] = DATA_W'(a);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_w_loaded", w_loaded, 1'b0);
    checkOutput("reset_rd_en", mem_rd_en, 1'b0);
    rst = 1'b1;

    $display("[TB] rejected feature load without weights");
    mark = rd_log.size();
    applyStimulus(1'b0, 1'b1, '0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t1_err_pulses", err_cnt, 1);
    checkOutput("t1_busy_cycles", busy_cnt, 0);
    checkOutput("t1_reads", rd_log.size() - mark, 0);

    $display("[TB] weight preload");
    mark = rd_log.size(); wmark = w_log.size();
    applyStimulus(1'b1, 1'b0, '0);
    waitDone(1'b1, "t2_wl_done");
    checkReads("t2_reads", mark, 0, 1, 2, 3);
    checkOutput("t2_shift_count", w_log.size() - wmark, 2);
    checkOutput("t2_shift0", w_log[wmark], 16'h0302);
    checkOutput("t2_shift1", w_log[wmark + 1], 16'h0100);
    checkOutput("t2_w_loaded", w_loaded, 1'b1);

    $display("[TB] feature load base 9");
    mark = rd_log.size(); fmark = f_log.size();
    applyStimulus(1'b0, 1'b1, 6'd9);
    waitDone(1'b0, "t3_fl_done");
    checkReads("t3_reads", mark, 9, 10, 13, 14);
    checkOutput("t3_stream_count", f_log.size() - fmark, 3);
    checkOutput("t3_stream0", f_log[fmark], {2'b01, 16'h0009});
    checkOutput("t3_stream1", f_log[fmark + 1], {2'b11, 16'h0A0D});
    checkOutput("t3_stream2", f_log[fmark + 2], {2'b10, 16'h0E00});
    checkOutput("t3_w_loaded", w_loaded, 1'b1);

    $display("[TB] successive feature windows");
    bases[0] = 10; bases[1] = 13; bases[2] = 14;
    for (int b = 0; b < 3; b++) begin
      mark = rd_log.size();
      applyStimulus(1'b0, 1'b1, ADDR_W'(bases[b]));
      waitDone(1'b0, $sformatf("t4_fl_done_%0d", bases[b]));
      checkReads($sformatf("t4_reads_%0d", bases[b]), mark,
                 bases[b], bases[b] + 1, bases[b] + FMAP_W, bases[b] + FMAP_W + 1);
    end

    $display("[TB] simultaneous starts and starts while busy");
    mark = rd_log.size(); fmark = f_log.size(); ecnt = err_cnt;
    applyStimulus(1'b1, 1'b1, 6'd20);
    #1;
    checkOutput("t5_w_loaded_drop", w_loaded, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 6'd30);
    waitDone(1'b1, "t5_wl_done");
    checkReads("t5_reads", mark, 0, 1, 2, 3);
    checkOutput("t5_no_err", err_cnt - ecnt, 0);
    checkOutput("t5_no_stream", f_log.size() - fmark, 0);

    $display("[TB] wrapping window and reset mid-stream");
    mark = rd_log.size(); fdcnt = fdone_cnt;
    applyStimulus(1'b0, 1'b1, 6'd62);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (f_valid == 2'b11);
    end
    checkOutput("t6_stream_reached", seen, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_busy_async", busy, 1'b0);
    checkOutput("t6_f_valid_async", f_valid, 2'b00);
    checkOutput("t6_w_loaded_async", w_loaded, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t6_no_fl_done", fdone_cnt - fdcnt, 0);
    checkReads("t6_reads", mark, 62, 63, 2, 3);
    rst = 1'b1;
    ecnt = err_cnt;
    applyStimulus(1'b0, 1'b1, 6'd9);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_err_after_reset", err_cnt - ecnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
